// File: rtl/bpu_pkg.sv
// Shared branch-predictor definitions: branch kinds, 2-bit counter states and counter helpers.
package bpu_pkg;

    typedef enum logic [2:0] {
        BT_NONE     = 3'd0,
        BT_BRANCH   = 3'd1,
        BT_JUMP     = 3'd2,
        BT_JUMP_IND = 3'd3,
        BT_CALL     = 3'd4,
        BT_RETURN   = 3'd5
    } branchType_e;

    typedef enum logic [1:0] {
        PS_STRONG_NT = 2'b00,
        PS_WEAK_NT   = 2'b01,
        PS_WEAK_T    = 2'b10,
        PS_STRONG_T  = 2'b11
    } predState_e;

    // Encodings 6 and 7 carry no meaning and behave exactly like NONE.
    function automatic logic [2:0] normType(input logic [2:0] t);
        return (t > 3'd5) ? 3'd0 : t;
    endfunction

    function automatic logic [1:0] satCount(input logic [1:0] s, input logic taken);
        if (taken) begin
            return (s == 2'b11) ? 2'b11 : s + 2'd1;
        end
        return (s == 2'b00) ? 2'b00 : s - 2'd1;
    endfunction

endpackage

// File: rtl/bpu_ras.sv
// Return-address stack with a speculative pointer/count and a committed copy used to recover after a restart.
module bpu_ras #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic [31:0] pushAddr_i,
    input  logic        commitPush_i,
    input  logic        commitPop_i,
    input  logic        restore_i,
    output logic [31:0] top_o,
    output logic        empty_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   cnt_t;

    localparam cnt_t FULL = cnt_t'(DEPTH);

    logic [31:0] stack_q [DEPTH];
    ptr_t specPtr_q, specPtr_d, cmtPtr_q, cmtPtr_d;
    cnt_t specCnt_q, specCnt_d, cmtCnt_q, cmtCnt_d;

    // Pushing when full wraps onto the oldest entry; popping when empty is ignored.
    always_comb begin
        cmtPtr_d  = cmtPtr_q;
        cmtCnt_d  = cmtCnt_q;
        specPtr_d = specPtr_q;
        specCnt_d = specCnt_q;
        if (commitPush_i) begin
            cmtPtr_d = cmtPtr_q + ptr_t'(1);
            if (cmtCnt_q != FULL) cmtCnt_d = cmtCnt_q + cnt_t'(1);
        end else if (commitPop_i && cmtCnt_q != '0) begin
            cmtPtr_d = cmtPtr_q - ptr_t'(1);
            cmtCnt_d = cmtCnt_q - cnt_t'(1);
        end
        if (push_i) begin
            specPtr_d = specPtr_q + ptr_t'(1);
            if (specCnt_q != FULL) specCnt_d = specCnt_q + cnt_t'(1);
        end else if (pop_i && specCnt_q != '0) begin
            specPtr_d = specPtr_q - ptr_t'(1);
            specCnt_d = specCnt_q - cnt_t'(1);
        end
        if (restore_i) begin
            specPtr_d = cmtPtr_d;
            specCnt_d = cmtCnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            specPtr_q <= '0;
            specCnt_q <= '0;
            cmtPtr_q  <= '0;
            cmtCnt_q  <= '0;
        end else begin
            specPtr_q <= specPtr_d;
            specCnt_q <= specCnt_d;
            cmtPtr_q  <= cmtPtr_d;
            cmtCnt_q  <= cmtCnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !clear_i && push_i) stack_q[specPtr_q] <= pushAddr_i;
    end

    assign top_o   = stack_q[specPtr_q - ptr_t'(1)];
    assign empty_o = (specCnt_q == '0);

endmodule

// File: rtl/branch_predictor.sv
// Branch predictor: branch cache (direct-mapped or 2-way), 2-bit counter table, optional RAS.
// Define BPU_RAS_EN to build the return-address stack used for RETURN targets.
module branch_predictor
    import bpu_pkg::*;
#(
    parameter int BC_SIZE  = 8,
    parameter int BC_ASSOC = 1,
    parameter int PS_SIZE  = 8,
    parameter int RAS_SIZE = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bpu_flush,
    input  logic [31:0] fch_pc_nxt,
    input  logic        fch_predict,
    input  logic [31:0] fch_pc_r,
    input  logic        fch_valid_r,
    input  logic        wrb_restart,
    input  logic        wrb_update_bpu,
    input  logic        wrb_was_pred,
    input  logic [1:0]  wrb_pred_state,
    input  logic [2:0]  wrb_index,
    input  logic [31:0] wrb_pc,
    input  logic        wrb_mispred_dir,
    input  logic        wrb_mispred_typ,
    input  logic        wrb_mispred_tgt,
    input  logic        wrb_direction,
    input  logic [2:0]  wrb_branch_type,
    input  logic [31:0] wrb_target,
    output logic        bpu_predicted,
    output logic        bpu_pred_taken,
    output logic [2:0]  bpu_pred_type,
    output logic [1:0]  bpu_pred_state,
    output logic [31:0] bpu_pred_target
);
    localparam int SETS  = 1 << BC_SIZE;
    localparam int TAG_W = 30 - BC_SIZE;
    localparam int PS_N  = 1 << PS_SIZE;

    // Storage is always sized for two ways; a direct-mapped build never validates way 1.
    logic              bcValid_q [2][SETS];
    logic [TAG_W-1:0]  bcTag_q   [2][SETS];
    logic [2:0]        bcType_q  [2][SETS];
    logic [29:0]       bcTgt_q   [2][SETS];
    logic              lru_q     [SETS];
    logic [1:0]        ps_q      [PS_N];

    logic        predicted_q;
    logic [1:0]  state_q;
    logic [2:0]  type_q;
    logic [31:0] target_q;

    logic [BC_SIZE-1:0] lkSet, upSet;
    logic [TAG_W-1:0]   lkTag, upTag;
    logic [PS_SIZE-1:0] lkPs, upPs;
    logic               lkHit, lkWay, upHit, upHitWay, upInv, upInvWay, upWay;
    logic [2:0]         lkType, upType;
    logic [1:0]         lkState;
    logic [31:0]        lkTarget;
    logic               allocEn, fixEn, dataWe;
    logic               unusedBits;

`ifdef BPU_RAS_EN
    logic        rasSpec, rasEmpty;
    logic [31:0] rasTop;

    assign rasSpec = fch_predict & fch_valid_r & predicted_q;

    bpu_ras #(.DEPTH_LOG2(RAS_SIZE)) u_ras (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (bpu_flush),
        .push_i       (rasSpec && type_q == BT_CALL),
        .pop_i        (rasSpec && type_q == BT_RETURN),
        .pushAddr_i   (fch_pc_r + 32'd4),
        .commitPush_i (wrb_update_bpu && upType == BT_CALL),
        .commitPop_i  (wrb_update_bpu && upType == BT_RETURN),
        .restore_i    (wrb_restart),
        .top_o        (rasTop),
        .empty_o      (rasEmpty)
    );

    assign unusedBits = ^{wrb_index, wrb_mispred_dir, fch_pc_nxt[1:0], wrb_pc[1:0], wrb_target[1:0]};
`else
    localparam int unusedRasSize = RAS_SIZE;
    assign unusedBits = ^{wrb_index, wrb_mispred_dir, fch_pc_nxt[1:0], wrb_pc[1:0], wrb_target[1:0],
                          fch_pc_r, fch_valid_r, wrb_restart};
`endif

    assign lkSet = fch_pc_nxt[BC_SIZE+1:2];
    assign lkTag = fch_pc_nxt[31:BC_SIZE+2];
    assign lkPs  = fch_pc_nxt[PS_SIZE+1:2];
    assign upSet = wrb_pc[BC_SIZE+1:2];
    assign upTag = wrb_pc[31:BC_SIZE+2];
    assign upPs  = wrb_pc[PS_SIZE+1:2];

    always_comb begin
        lkHit = 1'b0;
        lkWay = 1'b0;
        for (int w = BC_ASSOC - 1; w >= 0; w--) begin
            if (bcValid_q[w][lkSet] && bcTag_q[w][lkSet] == lkTag) begin
                lkHit = 1'b1;
                lkWay = w[0];
            end
        end
        lkType  = bcType_q[lkWay][lkSet];
        lkState = PS_STRONG_NT;
        case (lkType)
            BT_BRANCH:                                lkState = ps_q[lkPs];
            BT_JUMP, BT_JUMP_IND, BT_CALL, BT_RETURN: lkState = PS_STRONG_T;
            default: ;
        endcase
        lkTarget = {bcTgt_q[lkWay][lkSet], 2'b00};
`ifdef BPU_RAS_EN
        if (lkType == BT_RETURN && !rasEmpty) lkTarget = rasTop;
`endif
    end

    // Write way: matching entry first, then a free way, then the least recently used one.
    always_comb begin
        upHit    = 1'b0;
        upHitWay = 1'b0;
        upInv    = 1'b0;
        upInvWay = 1'b0;
        for (int w = BC_ASSOC - 1; w >= 0; w--) begin
            if (bcValid_q[w][upSet] && bcTag_q[w][upSet] == upTag) begin
                upHit    = 1'b1;
                upHitWay = w[0];
            end
            if (!bcValid_q[w][upSet]) begin
                upInv    = 1'b1;
                upInvWay = w[0];
            end
        end
        if (upHit)      upWay = upHitWay;
        else if (upInv) upWay = upInvWay;
        else            upWay = (BC_ASSOC == 2) ? lru_q[upSet] : 1'b0;
        upType  = normType(wrb_branch_type);
        allocEn = wrb_update_bpu & ~wrb_was_pred;
        fixEn   = wrb_update_bpu & wrb_was_pred & upHit;
        dataWe  = allocEn | (fixEn & (wrb_mispred_typ | wrb_mispred_tgt));
    end

    always_ff @(posedge clk) begin
        if (!reset && !bpu_flush && dataWe) begin
            bcTag_q[upWay][upSet]  <= upTag;
            bcType_q[upWay][upSet] <= upType;
            bcTgt_q[upWay][upSet]  <= wrb_target[31:2];
        end
    end

    // Lookups read pre-update contents; a same-cycle write to the same set wins the LRU bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                bcValid_q[0][s] <= 1'b0;
                bcValid_q[1][s] <= 1'b0;
                lru_q[s]        <= 1'b0;
            end
            for (int p = 0; p < PS_N; p++) ps_q[p] <= PS_WEAK_NT;
            predicted_q <= 1'b0;
            state_q     <= 2'b00;
            type_q      <= 3'd0;
            target_q    <= 32'd0;
        end else if (bpu_flush) begin
            for (int s = 0; s < SETS; s++) begin
                bcValid_q[0][s] <= 1'b0;
                bcValid_q[1][s] <= 1'b0;
            end
            predicted_q <= 1'b0;
            state_q     <= 2'b00;
            type_q      <= 3'd0;
            target_q    <= 32'd0;
        end else begin
            if (fch_predict) begin
                predicted_q <= lkHit;
                state_q     <= lkHit ? lkState : 2'b00;
                type_q      <= lkHit ? lkType : 3'd0;
                target_q    <= lkHit ? lkTarget : 32'd0;
                if (lkHit) lru_q[lkSet] <= ~lkWay;
            end
            if (allocEn) begin
                bcValid_q[upWay][upSet] <= 1'b1;
                lru_q[upSet]            <= ~upWay;
                ps_q[upPs]              <= wrb_direction ? PS_WEAK_T : PS_WEAK_NT;
            end else if (wrb_update_bpu) begin
                if (upType == BT_BRANCH) ps_q[upPs] <= satCount(wrb_pred_state, wrb_direction);
                if (fixEn) begin
                    lru_q[upSet] <= ~upWay;
                    if (upType == BT_NONE) bcValid_q[upWay][upSet] <= 1'b0;
                end
            end
        end
    end

    assign bpu_predicted   = predicted_q;
    assign bpu_pred_taken  = predicted_q & state_q[1];
    assign bpu_pred_type   = type_q;
    assign bpu_pred_state  = state_q;
    assign bpu_pred_target = target_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: a direct-mapped and a 2-way instance see identical stimulus.
// Build with +define+BPU_RAS_EN to expect RAS-supplied RETURN targets.
`timescale 1ns/1ps
module tb_branch_predictor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, bpu_flush, fch_predict, fch_valid_r, wrb_restart, wrb_update_bpu, wrb_was_pred;
    logic        wrb_mispred_dir, wrb_mispred_typ, wrb_mispred_tgt, wrb_direction;
    logic [31:0] fch_pc_nxt, fch_pc_r, wrb_pc, wrb_target;
    logic [1:0]  wrb_pred_state;
    logic [2:0]  wrb_index, wrb_branch_type;

    logic        pred0, taken0, pred1, taken1;
    logic [2:0]  type0, type1;
    logic [1:0]  state0, state1;
    logic [31:0] tgt0, tgt1;

    int checks   = 0;
    int failures = 0;

`ifdef BPU_RAS_EN
    localparam logic [31:0] RET_TGT = 32'h304;
`else
    localparam logic [31:0] RET_TGT = 32'h0;
`endif

    branch_predictor #(.BC_ASSOC(1)) dut0 (
        .clk(clk), .reset(reset), .bpu_flush(bpu_flush), .fch_pc_nxt(fch_pc_nxt), .fch_predict(fch_predict),
        .fch_pc_r(fch_pc_r), .fch_valid_r(fch_valid_r), .wrb_restart(wrb_restart),
        .wrb_update_bpu(wrb_update_bpu), .wrb_was_pred(wrb_was_pred), .wrb_pred_state(wrb_pred_state),
        .wrb_index(wrb_index), .wrb_pc(wrb_pc), .wrb_mispred_dir(wrb_mispred_dir),
        .wrb_mispred_typ(wrb_mispred_typ), .wrb_mispred_tgt(wrb_mispred_tgt), .wrb_direction(wrb_direction),
        .wrb_branch_type(wrb_branch_type), .wrb_target(wrb_target),
        .bpu_predicted(pred0), .bpu_pred_taken(taken0), .bpu_pred_type(type0),
        .bpu_pred_state(state0), .bpu_pred_target(tgt0)
    );

    branch_predictor #(.BC_ASSOC(2)) dut1 (
        .clk(clk), .reset(reset), .bpu_flush(bpu_flush), .fch_pc_nxt(fch_pc_nxt), .fch_predict(fch_predict),
        .fch_pc_r(fch_pc_r), .fch_valid_r(fch_valid_r), .wrb_restart(wrb_restart),
        .wrb_update_bpu(wrb_update_bpu), .wrb_was_pred(wrb_was_pred), .wrb_pred_state(wrb_pred_state),
        .wrb_index(wrb_index), .wrb_pc(wrb_pc), .wrb_mispred_dir(wrb_mispred_dir),
        .wrb_mispred_typ(wrb_mispred_typ), .wrb_mispred_tgt(wrb_mispred_tgt), .wrb_direction(wrb_direction),
        .wrb_branch_type(wrb_branch_type), .wrb_target(wrb_target),
        .bpu_predicted(pred1), .bpu_pred_taken(taken1), .bpu_pred_type(type1),
        .bpu_pred_state(state1), .bpu_pred_target(tgt1)
    );

    typedef struct {
        string       name;
        int          dutSel;
        logic        pred;
        logic        taken;
        logic [2:0]  typ;
        logic [1:0]  state;
        logic [31:0] tgt;
    } expT;

    typedef struct {
        string       name;
        bit          isLookup;
        bit          wasPred;
        logic [31:0] pc;
        logic [2:0]  typ;
        bit          dir;
        logic [1:0]  pst;
        bit          misTgt;
        logic [31:0] tgt;
        bit          ePred;
        logic [1:0]  eState;
        logic [2:0]  eType;
        logic [31:0] eTgt;
    } vecT;

    expT sb[$];
    vecT vecs[$];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vecT mkLookup(string name, logic [31:0] pc, bit ePred, logic [1:0] eState,
                                     logic [2:0] eType, logic [31:0] eTgt);
        vecT v;
        v = '{name: name, isLookup: 1'b1, wasPred: 1'b0, pc: pc, typ: 3'd0, dir: 1'b0, pst: 2'b00,
              misTgt: 1'b0, tgt: 32'h0, ePred: ePred, eState: eState, eType: eType, eTgt: eTgt};
        return v;
    endfunction

    function automatic vecT mkUpdate(string name, bit wasPred, logic [31:0] pc, logic [2:0] typ, bit dir,
                                     logic [1:0] pst, bit misTgt, logic [31:0] tgt);
        vecT v;
        v = '{name: name, isLookup: 1'b0, wasPred: wasPred, pc: pc, typ: typ, dir: dir, pst: pst,
              misTgt: misTgt, tgt: tgt, ePred: 1'b0, eState: 2'b00, eType: 3'd0, eTgt: 32'h0};
        return v;
    endfunction

    task automatic clearInputs();
        bpu_flush       = 1'b0;
        fch_predict     = 1'b0;
        fch_pc_nxt      = 32'h0;
        fch_pc_r        = 32'h0;
        fch_valid_r     = 1'b0;
        wrb_restart     = 1'b0;
        wrb_update_bpu  = 1'b0;
        wrb_was_pred    = 1'b0;
        wrb_pred_state  = 2'b00;
        wrb_index       = 3'd0;
        wrb_pc          = 32'h0;
        wrb_mispred_dir = 1'b0;
        wrb_mispred_typ = 1'b0;
        wrb_mispred_tgt = 1'b0;
        wrb_direction   = 1'b0;
        wrb_branch_type = 3'd0;
        wrb_target      = 32'h0;
    endtask

    task automatic cmpVal(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic expectOne(int sel, string name, bit pred, logic [1:0] state, logic [2:0] typ,
                             logic [31:0] tgt);
        expT e;
        e = '{name: name, dutSel: sel, pred: pred, taken: pred & state[1], typ: typ, state: state, tgt: tgt};
        sb.push_back(e);
    endtask

    task automatic expectBoth(string name, bit pred, logic [1:0] state, logic [2:0] typ, logic [31:0] tgt);
        expectOne(0, name, pred, state, typ, tgt);
        expectOne(1, name, pred, state, typ, tgt);
    endtask

    task automatic checkOutput();
        expT   e;
        string n;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n = $sformatf("%s[dut%0d]", e.name, e.dutSel);
            cmpVal({n, ".predicted"}, 32'(e.dutSel != 0 ? pred1 : pred0), 32'(e.pred));
            cmpVal({n, ".taken"}, 32'(e.dutSel != 0 ? taken1 : taken0), 32'(e.taken));
            cmpVal({n, ".type"}, 32'(e.dutSel != 0 ? type1 : type0), 32'(e.typ));
            cmpVal({n, ".state"}, 32'(e.dutSel != 0 ? state1 : state0), 32'(e.state));
            cmpVal({n, ".target"}, e.dutSel != 0 ? tgt1 : tgt0, e.tgt);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        checkOutput();
        clearInputs();
    endtask

    task automatic driveLookup(logic [31:0] pc);
        fch_predict = 1'b1;
        fch_pc_nxt  = pc;
    endtask

    task automatic driveUpdate(bit wasPred, logic [31:0] pc, logic [2:0] typ, bit dir, logic [1:0] pst,
                               bit misTgt, logic [31:0] tgt);
        wrb_update_bpu  = 1'b1;
        wrb_was_pred    = wasPred;
        wrb_pc          = pc;
        wrb_branch_type = typ;
        wrb_direction   = dir;
        wrb_pred_state  = pst;
        wrb_mispred_tgt = misTgt;
        wrb_mispred_dir = wasPred & (dir != pst[1]);
        wrb_target      = tgt;
    endtask

    task automatic applyStimulus(vecT v);
        if (v.isLookup) begin
            driveLookup(v.pc);
            expectBoth(v.name, v.ePred, v.eState, v.eType, v.eTgt);
        end else begin
            driveUpdate(v.wasPred, v.pc, v.typ, v.dir, v.pst, v.misTgt, v.tgt);
        end
        step();
    endtask

    initial begin
        clearInputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        expectBoth("reset_outputs", 1'b0, 2'b00, 3'd0, 32'h0);
        checkOutput();

        vecs.push_back(mkLookup("cold_miss", 32'h100, 1'b0, 2'b00, 3'd0, 32'h0));
        vecs.push_back(mkUpdate("alloc_100", 1'b0, 32'h100, 3'd1, 1'b1, 2'b00, 1'b0, 32'h200));
        vecs.push_back(mkLookup("alloc_branch", 32'h100, 1'b1, 2'b10, 3'd1, 32'h200));
        vecs.push_back(mkUpdate("nt_from_10", 1'b1, 32'h100, 3'd1, 1'b0, 2'b10, 1'b0, 32'h200));
        vecs.push_back(mkLookup("dec_10_01", 32'h100, 1'b1, 2'b01, 3'd1, 32'h200));
        vecs.push_back(mkUpdate("nt_from_01", 1'b1, 32'h100, 3'd1, 1'b0, 2'b01, 1'b0, 32'h200));
        vecs.push_back(mkLookup("dec_01_00", 32'h100, 1'b1, 2'b00, 3'd1, 32'h200));
        vecs.push_back(mkUpdate("nt_from_00", 1'b1, 32'h100, 3'd1, 1'b0, 2'b00, 1'b0, 32'h200));
        vecs.push_back(mkLookup("sat_00", 32'h100, 1'b1, 2'b00, 3'd1, 32'h200));
        vecs.push_back(mkUpdate("t_from_00", 1'b1, 32'h100, 3'd1, 1'b1, 2'b00, 1'b0, 32'h200));
        vecs.push_back(mkLookup("inc_00_01", 32'h100, 1'b1, 2'b01, 3'd1, 32'h200));
        vecs.push_back(mkUpdate("alloc_jump", 1'b0, 32'h180, 3'd2, 1'b1, 2'b00, 1'b0, 32'h1000));
        vecs.push_back(mkLookup("jump_hit", 32'h180, 1'b1, 2'b11, 3'd2, 32'h1000));
        vecs.push_back(mkUpdate("alloc_jind", 1'b0, 32'h1C0, 3'd3, 1'b0, 2'b00, 1'b0, 32'h2224));
        vecs.push_back(mkLookup("jind_forced", 32'h1C0, 1'b1, 2'b11, 3'd3, 32'h2224));
        vecs.push_back(mkUpdate("fix_tgt", 1'b1, 32'h1C0, 3'd3, 1'b1, 2'b11, 1'b1, 32'h3000));
        vecs.push_back(mkLookup("rewrite_tgt", 32'h1C0, 1'b1, 2'b11, 3'd3, 32'h3000));
        vecs.push_back(mkUpdate("to_none", 1'b1, 32'h1C0, 3'd0, 1'b0, 2'b11, 1'b0, 32'h0));
        vecs.push_back(mkLookup("invalidated", 32'h1C0, 1'b0, 2'b00, 3'd0, 32'h0));
        vecs.push_back(mkLookup("other_set", 32'h104, 1'b0, 2'b00, 3'd0, 32'h0));
        vecs.push_back(mkLookup("tag_miss", 32'h500, 1'b0, 2'b00, 3'd0, 32'h0));
        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Outputs hold while fch_predict is low.
        driveLookup(32'h100);
        expectBoth("hold_pre", 1'b1, 2'b01, 3'd1, 32'h200);
        step();
        fch_pc_nxt = 32'h180;
        expectBoth("hold", 1'b1, 2'b01, 3'd1, 32'h200);
        step();

        // Same-set update and lookup: lookup sees the old target.
        driveLookup(32'h180);
        driveUpdate(1'b1, 32'h180, 3'd2, 1'b1, 2'b11, 1'b1, 32'h5000);
        expectBoth("no_bypass", 1'b1, 2'b11, 3'd2, 32'h1000);
        step();
        applyStimulus(mkLookup("after_fix", 32'h180, 1'b1, 2'b11, 3'd2, 32'h5000));

        // Flush clears outputs and beats a simultaneous allocate.
        bpu_flush = 1'b1;
        driveUpdate(1'b0, 32'h104, 3'd2, 1'b1, 2'b00, 1'b0, 32'h4000);
        expectBoth("flush_clear", 1'b0, 2'b00, 3'd0, 32'h0);
        step();
        applyStimulus(mkLookup("flush_miss", 32'h100, 1'b0, 2'b00, 3'd0, 32'h0));
        applyStimulus(mkLookup("flush_prio", 32'h104, 1'b0, 2'b00, 3'd0, 32'h0));

        // Aliasing PCs: 2-way keeps both, direct-mapped keeps the latest; then LRU replacement.
        applyStimulus(mkUpdate("alias_a", 1'b0, 32'h100, 3'd1, 1'b1, 2'b00, 1'b0, 32'h200));
        applyStimulus(mkUpdate("alias_b", 1'b0, 32'h500, 3'd2, 1'b1, 2'b00, 1'b0, 32'h600));
        applyStimulus(mkLookup("alias_500", 32'h500, 1'b1, 2'b11, 3'd2, 32'h600));
        driveLookup(32'h100);
        expectOne(0, "dm_alias_100", 1'b0, 2'b00, 3'd0, 32'h0);
        expectOne(1, "2way_alias_100", 1'b1, 2'b10, 3'd1, 32'h200);
        step();
        applyStimulus(mkUpdate("alias_c", 1'b0, 32'h900, 3'd3, 1'b1, 2'b00, 1'b0, 32'h940));
        applyStimulus(mkLookup("lru_evicted_500", 32'h500, 1'b0, 2'b00, 3'd0, 32'h0));
        driveLookup(32'h100);
        expectOne(0, "dm_after_900", 1'b0, 2'b00, 3'd0, 32'h0);
        expectOne(1, "lru_kept_100", 1'b1, 2'b10, 3'd1, 32'h200);
        step();
        applyStimulus(mkLookup("hit_900", 32'h900, 1'b1, 2'b11, 3'd3, 32'h940));

        // CALL consumed at fetch pushes 0x304; RETURN then predicts it until a restart empties the stack.
        applyStimulus(mkUpdate("alloc_call", 1'b0, 32'h300, 3'd4, 1'b1, 2'b00, 1'b0, 32'h800));
        applyStimulus(mkLookup("call_hit", 32'h300, 1'b1, 2'b11, 3'd4, 32'h800));
        driveLookup(32'h0);
        fch_valid_r = 1'b1;
        fch_pc_r    = 32'h300;
        expectBoth("call_consumed", 1'b0, 2'b00, 3'd0, 32'h0);
        step();
        applyStimulus(mkUpdate("alloc_ret", 1'b0, 32'h400, 3'd5, 1'b1, 2'b00, 1'b0, 32'h0));
        applyStimulus(mkLookup("ret_target", 32'h400, 1'b1, 2'b11, 3'd5, RET_TGT));
        wrb_restart = 1'b1;
        expectBoth("restart_hold", 1'b1, 2'b11, 3'd5, RET_TGT);
        step();
        applyStimulus(mkLookup("ret_after_restart", 32'h400, 1'b1, 2'b11, 3'd5, 32'h0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter BC_SIZE, default 8, log2 of branch-cache (BC) sets.
REQ-002 Parameter BC_ASSOC, default 1, 1 = direct-mapped, 2 = 2-way set-associative; other values illegal.
REQ-003 Parameter PS_SIZE, default 8, log2 of prediction-state (PS) counter table entries.
REQ-004 Parameter RAS_SIZE, default 3, log2 of return-address-stack entries.
REQ-005 Ports, in order (name, direction, width, meaning):
- clk in 1: the single clock.
- reset in 1: synchronous, active-high.
- bpu_flush in 1: invalidate the predictor.
- fch_pc_nxt in 32: next fetch PC.
- fch_predict in 1: look up fch_pc_nxt this edge.
- fch_pc_r in 32: current fetch PC.
- fch_valid_r in 1: current fetch is valid.
- wrb_restart in 1: pipeline flush.
- wrb_update_bpu in 1: update request.
- wrb_was_pred in 1: 1 = update an existing entry, 0 = allocate a new entry.
- wrb_pred_state in 2: state that was predicted.
- wrb_index in 3: instruction ID, informational only.
- wrb_pc in 32: PC of the resolving instruction.
- wrb_mispred_dir in 1, wrb_mispred_typ in 1, wrb_mispred_tgt in 1: misprediction flags.
- wrb_direction in 1: actual branch outcome.
- wrb_branch_type in 3: actual branch type.
- wrb_target in 32: actual target.
- bpu_predicted out 1, bpu_pred_taken out 1, bpu_pred_type out 3, bpu_pred_state out 2, bpu_pred_target out 32: prediction outputs.

Function
REQ-006 Branch types: 0 NONE, 1 BRANCH, 2 JUMP, 3 JUMP_IND, 4 CALL, 5 RETURN; 6 and 7 are treated as NONE.
REQ-007 State encoding: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken; bit 1 is the direction.
REQ-008 Addressing:
- BC set index = pc[BC_SIZE+1:2]; BC tag = pc[31:BC_SIZE+2].
- PS index = pc[PS_SIZE+1:2].
- Each BC entry holds valid, tag, type and target[31:2].
REQ-009 Lookup:
- When fch_predict=1, the BC and PS are read with fch_pc_nxt and the prediction outputs are registered at that edge, so they describe fch_pc_r one cycle later.
- When fch_predict=0, the outputs hold their values.
REQ-010 bpu_predicted = 1 when a valid way's tag matches; otherwise all prediction outputs are 0.
REQ-011 Predicted state per type:
- BRANCH: bpu_pred_state is the PS counter.
- JUMP, JUMP_IND, CALL and RETURN: bpu_pred_state is forced to 11.
- bpu_pred_taken = bpu_predicted & bpu_pred_state[1].
REQ-012 Predicted target: the stored target, except RETURN with a non-empty RAS, which uses the RAS top.
REQ-013 Speculative RAS, applied at an edge with fch_predict=1, fch_valid_r=1 and bpu_predicted=1:
- CALL pushes fch_pc_r+4.
- RETURN pops.
- Push when full wraps and overwrites the oldest entry; pop when empty leaves the count at 0.
REQ-014 Committed RAS pointer: updated by wrb_update_bpu with wrb_branch_type CALL (push) or RETURN (pop).
REQ-015 On wrb_restart the speculative pointer is set to the committed pointer.
REQ-016 Update with wrb_was_pred=0 (allocate):
- Write tag, type and target to the matching way; if none matches, to an invalid way; if none is invalid, to the LRU way.
- PS is initialised to 10 if wrb_direction=1, else 01.
REQ-017 Update with wrb_was_pred=1:
- For BRANCH, PS saturates toward wrb_direction starting from wrb_pred_state.
- If wrb_mispred_typ or wrb_mispred_tgt is set, the entry's type and target are rewritten.
- If wrb_branch_type=NONE, the entry is invalidated.
REQ-018 An update and a lookup to the same set in the same cycle: the lookup returns the pre-update contents; there is no bypass.
REQ-019 BC_ASSOC=2: one LRU bit per set, updated on every hit and every write.
REQ-020 bpu_flush:
- Clears all BC valid bits and both RAS pointers at the next edge.
- The PS table is untouched.
- The prediction outputs are cleared.
- bpu_flush has priority over a simultaneous update.

Reset
REQ-021 While reset=1 at an edge: all valid bits are 0, the RAS pointers and count are 0, the LRU bits are 0, all outputs are 0, and the PS entries are 01.

Configuration
REQ-022 Macro BPU_RAS_EN:
- Defined: the RAS of REQ-012 to REQ-015 is present.
- Undefined: no RAS logic; RETURN predicts the stored BC target.

Structure
REQ-023 Package bpu_pkg holds the branch-type constants, the state encodings and a saturating-counter function.
REQ-024 Sub-module bpu_ras implements the RAS (push, pop, top, restore from the committed pointer).

Verification
REQ-025 Reset, then a lookup of 0x100 -> bpu_predicted=0 and bpu_pred_target=0.
REQ-026 Allocate pc=0x100, BRANCH, taken, target=0x200; then a lookup of 0x100 -> predicted=1, state=10, taken=1, target=0x200, type=1.
REQ-027 Two not-taken updates of 0x100 with was_pred=1 -> state 10 to 01, then 01 to 00; a further not-taken update stays at 00.
REQ-028 With BPU_RAS_EN: CALL at 0x300 is consumed (push 0x304); then a RETURN entry at 0x400 with stored target 0x0 -> predicted target 0x304.
REQ-029 With the RAS holding 0x304, wrb_restart with the committed pointer at 0 -> a subsequent RETURN prediction uses the stored target.
REQ-030 bpu_flush after allocating 0x100 -> the next lookup of 0x100 gives predicted=0; with BC_ASSOC=2, two aliasing PCs 0x100 and 0x500 (BC_SIZE=8) both hit.
